// File: rtl/k423_id_pkg.sv
// Shared types and constants for the ID-stage decoded-instruction queue.
// The info vector layout is common to every group so EX can slice it without re-decoding.
package k423_id_pkg;

  localparam int CORE_XLEN     = 32;
  localparam int CORE_INST_W   = 32;
  localparam int INST_GRP_W    = 5;
  localparam int INST_INFO_W   = 7;
  localparam int INST_SYS_W    = 6;
  localparam int INST_RSDIDX_W = 5;
  localparam int RSD_SIZE_W    = 2;

  localparam int GRP_ALU = 0;
  localparam int GRP_MDU = 1;
  localparam int GRP_LSU = 2;
  localparam int GRP_BJU = 3;
  localparam int GRP_CSR = 4;

  localparam int SYS_FENCE   = 0;
  localparam int SYS_FENCE_I = 1;
  localparam int SYS_ECALL   = 2;
  localparam int SYS_EBREAK  = 3;
  localparam int SYS_MRET    = 4;
  localparam int SYS_WFI     = 5;

  // info[2:0] funct3, [3] sub/sra, [4] immediate operand (ALU) or zimm form (CSR),
  // [5] LUI / JAL / store, [6] AUIPC / JALR / load
  localparam int INFO_F3  = 0;
  localparam int INFO_ALT = 3;
  localparam int INFO_IMM = 4;
  localparam int INFO_K5  = 5;
  localparam int INFO_K6  = 6;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] INST_WFI    = 32'h1050_0073;

  typedef struct packed {
    logic [INST_GRP_W-1:0]    grp;
    logic [INST_INFO_W-1:0]   info;
    logic [INST_SYS_W-1:0]    sys;
    logic                     ill;
    logic                     rs1_vld;
    logic                     rs2_vld;
    logic                     rd_vld;
    logic [INST_RSDIDX_W-1:0] rs1_idx;
    logic [INST_RSDIDX_W-1:0] rs2_idx;
    logic [INST_RSDIDX_W-1:0] rd_idx;
    logic [CORE_XLEN-1:0]     imm;
    logic [RSD_SIZE_W-1:0]    load_size;
    logic [RSD_SIZE_W-1:0]    store_size;
  } dec_t;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    dec_t                 dec;
  } dec_rec_t;

endpackage

// File: rtl/k423_id_decode_rv32.sv
// Combinational RV32I(+M, +Zicsr) decoder producing one queue record (without pc).
// Illegal encodings collapse to an all-zero record with only the ill flag set.
module k423_id_decode_rv32
  import k423_id_pkg::*;
#(
  parameter bit EN_M     = 1'b1,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic [CORE_INST_W-1:0] inst,
  output dec_t                   dec
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt = {27'b0, inst[24:20]};

  dec_t d;
  logic ill;

  // NOTE: every field gets a default before the case so no path leaves a latch behind.
  always_comb begin
    d   = '0;
    ill = 1'b0;
    case (opc)
      OPC_OP: begin
        d.rs1_vld = 1'b1;
        d.rs2_vld = 1'b1;
        d.rd_vld  = 1'b1;
        d.info[INFO_F3 +: 3] = f3;
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          d.grp[GRP_ALU]  = 1'b1;
          d.info[INFO_ALT] = f7[5];
        end else if (f7 == 7'b0000001 && EN_M) begin
          d.grp[GRP_MDU] = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        d.grp[GRP_ALU]  = 1'b1;
        d.rs1_vld       = 1'b1;
        d.rd_vld        = 1'b1;
        d.info[INFO_F3 +: 3] = f3;
        d.info[INFO_IMM] = 1'b1;
        d.imm            = imm_i;
        if (f3 == 3'b001) begin
          ill   = (f7 != 7'b0000000);
          d.imm = shamt;
        end else if (f3 == 3'b101) begin
          ill   = !(f7 == 7'b0000000 || f7 == 7'b0100000);
          d.info[INFO_ALT] = f7[5];
          d.imm = shamt;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        d.grp[GRP_ALU]   = 1'b1;
        d.rd_vld         = 1'b1;
        d.info[INFO_K5]  = (opc == OPC_LUI);
        d.info[INFO_K6]  = (opc == OPC_AUIPC);
        d.imm            = imm_u;
      end
      OPC_BRANCH: begin
        ill            = (f3 == 3'b010 || f3 == 3'b011);
        d.grp[GRP_BJU] = 1'b1;
        d.rs1_vld      = 1'b1;
        d.rs2_vld      = 1'b1;
        d.info[INFO_F3 +: 3] = f3;
        d.imm          = imm_b;
      end
      OPC_JAL: begin
        d.grp[GRP_BJU]  = 1'b1;
        d.rd_vld        = 1'b1;
        d.info[INFO_K5] = 1'b1;
        d.imm           = imm_j;
      end
      OPC_JALR: begin
        ill             = (f3 != 3'b000);
        d.grp[GRP_BJU]  = 1'b1;
        d.rs1_vld       = 1'b1;
        d.rd_vld        = 1'b1;
        d.info[INFO_K6] = 1'b1;
        d.imm           = imm_i;
      end
      OPC_LOAD: begin
        ill             = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        d.grp[GRP_LSU]  = 1'b1;
        d.rs1_vld       = 1'b1;
        d.rd_vld        = 1'b1;
        d.info[INFO_F3 +: 3] = f3;
        d.info[INFO_K6] = 1'b1;
        d.imm           = imm_i;
        d.load_size     = f3[1:0];
      end
      OPC_STORE: begin
        ill             = (f3 > 3'b010);
        d.grp[GRP_LSU]  = 1'b1;
        d.rs1_vld       = 1'b1;
        d.rs2_vld       = 1'b1;
        d.info[INFO_F3 +: 3] = f3;
        d.info[INFO_K5] = 1'b1;
        d.imm           = imm_s;
        d.store_size    = f3[1:0];
      end
      OPC_MISC_MEM: begin
        if (f3 == 3'b000)      d.sys[SYS_FENCE]   = 1'b1;
        else if (f3 == 3'b001) d.sys[SYS_FENCE_I] = 1'b1;
        else                   ill = 1'b1;
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          case (inst)
            INST_ECALL:  d.sys[SYS_ECALL]  = 1'b1;
            INST_EBREAK: d.sys[SYS_EBREAK] = 1'b1;
            INST_MRET:   d.sys[SYS_MRET]   = 1'b1;
            INST_WFI:    d.sys[SYS_WFI]    = 1'b1;
            default:     ill = 1'b1;
          endcase
        end else if (f3 == 3'b100 || !EN_ZICSR) begin
          ill = 1'b1;
        end else begin
          // rs1 field carries either the source register or the 5-bit zimm
          d.grp[GRP_CSR]   = 1'b1;
          d.info[INFO_F3 +: 3] = f3;
          d.info[INFO_IMM] = f3[2];
          d.rs1_vld        = ~f3[2];
          d.rd_vld         = 1'b1;
          d.imm            = {20'b0, inst[31:20]};
        end
      end
      default: ill = 1'b1;
    endcase

    d.rs1_idx = (d.rs1_vld || d.grp[GRP_CSR]) ? inst[19:15] : '0;
    d.rs2_idx = d.rs2_vld ? inst[24:20] : '0;
    d.rd_idx  = d.rd_vld  ? inst[11:7]  : '0;

    if (inst[1:0] != 2'b11 || inst == '0 || inst == '1) ill = 1'b1;
    if (ill) begin
      d     = '0;
      d.ill = 1'b1;
    end
    dec = d;
  end

endmodule

// File: rtl/k423_id_decq.sv
// ID-stage decoded-instruction queue: decode at enqueue, FIFO of records, head to EX.
// if_rdy_o depends only on registered occupancy, so EX back-pressure never reaches IF combinationally.
module k423_id_decq
  import k423_id_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter bit EN_M     = 1'b1,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         flush_i,
  input  logic                         if_vld_i,
  output logic                         if_rdy_o,
  input  logic [CORE_INST_W-1:0]       if_inst_i,
  input  logic [CORE_XLEN-1:0]         if_pc_i,
  output logic                         id_vld_o,
  input  logic                         ex_rdy_i,
  output logic [CORE_XLEN-1:0]         id_pc_o,
  output logic [INST_GRP_W-1:0]        id_grp_o,
  output logic [INST_INFO_W-1:0]       id_info_o,
  output logic [INST_SYS_W-1:0]        id_sys_o,
  output logic                         id_ill_o,
  output logic                         id_rs1_vld_o,
  output logic                         id_rs2_vld_o,
  output logic                         id_rd_vld_o,
  output logic [INST_RSDIDX_W-1:0]     id_rs1_idx_o,
  output logic [INST_RSDIDX_W-1:0]     id_rs2_idx_o,
  output logic [INST_RSDIDX_W-1:0]     id_rd_idx_o,
  output logic [CORE_XLEN-1:0]         id_imm_o,
  output logic [RSD_SIZE_W-1:0]        id_load_size_o,
  output logic [RSD_SIZE_W-1:0]        id_store_size_o,
  output logic [$clog2(DEPTH+1)-1:0]   id_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  dec_rec_t          mem [DEPTH];
  dec_t              dec;
  dec_rec_t          head;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  cnt;
  logic              enq, deq;

  k423_id_decode_rv32 #(.EN_M(EN_M), .EN_ZICSR(EN_ZICSR)) u_dec (
    .inst (if_inst_i),
    .dec  (dec)
  );

  assign if_rdy_o = (cnt != CNT_W'(DEPTH));
  assign id_vld_o = (cnt != '0);
  assign enq      = if_vld_i & if_rdy_o & ~flush_i;
  assign deq      = id_vld_o & ex_rdy_i & ~flush_i;

  // NOTE: entry storage is deliberately not reset; stale payload is masked by id_vld_o below.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= '{pc: if_pc_i, dec: dec};
  end

  // NOTE: state flops use non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (enq) wptr <= wptr + PTR_W'(1);
      if (deq) rptr <= rptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = id_vld_o ? mem[rptr] : '0;

  assign id_pc_o         = head.pc;
  assign id_grp_o        = head.dec.grp;
  assign id_info_o       = head.dec.info;
  assign id_sys_o        = head.dec.sys;
  assign id_ill_o        = head.dec.ill;
  assign id_rs1_vld_o    = head.dec.rs1_vld;
  assign id_rs2_vld_o    = head.dec.rs2_vld;
  assign id_rd_vld_o     = head.dec.rd_vld;
  assign id_rs1_idx_o    = head.dec.rs1_idx;
  assign id_rs2_idx_o    = head.dec.rs2_idx;
  assign id_rd_idx_o     = head.dec.rd_idx;
  assign id_imm_o        = head.dec.imm;
  assign id_load_size_o  = head.dec.load_size;
  assign id_store_size_o = head.dec.store_size;
  assign id_cnt_o        = cnt;

endmodule

// File: tb/tb_k423_id_decq.sv
// Bench for k423_id_decq: two instances (full ISA / no M, no Zicsr) share one input stream
// and are checked against a queue-based reference model with an ISA-level decode function.
module tb_k423_id_decq;
  import k423_id_pkg::*;

  localparam int DEPTH = 2;

  logic        clk, rst_n, flush, if_vld, ex_rdy;
  logic [31:0] if_inst, if_pc;

  logic        if_rdy_a, id_vld_a, ill_a, rs1v_a, rs2v_a, rdv_a;
  logic [31:0] pc_a, imm_a;
  logic [4:0]  grp_a, rs1i_a, rs2i_a, rdi_a;
  logic [6:0]  info_a;
  logic [5:0]  sys_a;
  logic [1:0]  lsz_a, ssz_a, cnt_a;

  logic        if_rdy_b, id_vld_b, ill_b, rs1v_b, rs2v_b, rdv_b;
  logic [31:0] pc_b, imm_b;
  logic [4:0]  grp_b, rs1i_b, rs2i_b, rdi_b;
  logic [6:0]  info_b;
  logic [5:0]  sys_b;
  logic [1:0]  lsz_b, ssz_b, cnt_b;

  dec_rec_t act_a, act_b;
  assign act_a = {pc_a, grp_a, info_a, sys_a, ill_a, rs1v_a, rs2v_a, rdv_a, rs1i_a, rs2i_a, rdi_a, imm_a, lsz_a, ssz_a};
  assign act_b = {pc_b, grp_b, info_b, sys_b, ill_b, rs1v_b, rs2v_b, rdv_b, rs1i_b, rs2i_b, rdi_b, imm_b, lsz_b, ssz_b};

  k423_id_decq #(.DEPTH(DEPTH), .EN_M(1'b1), .EN_ZICSR(1'b1)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .if_vld_i(if_vld), .if_rdy_o(if_rdy_a),
    .if_inst_i(if_inst), .if_pc_i(if_pc), .id_vld_o(id_vld_a), .ex_rdy_i(ex_rdy),
    .id_pc_o(pc_a), .id_grp_o(grp_a), .id_info_o(info_a), .id_sys_o(sys_a), .id_ill_o(ill_a),
    .id_rs1_vld_o(rs1v_a), .id_rs2_vld_o(rs2v_a), .id_rd_vld_o(rdv_a),
    .id_rs1_idx_o(rs1i_a), .id_rs2_idx_o(rs2i_a), .id_rd_idx_o(rdi_a), .id_imm_o(imm_a),
    .id_load_size_o(lsz_a), .id_store_size_o(ssz_a), .id_cnt_o(cnt_a)
  );

  k423_id_decq #(.DEPTH(DEPTH), .EN_M(1'b0), .EN_ZICSR(1'b0)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .if_vld_i(if_vld), .if_rdy_o(if_rdy_b),
    .if_inst_i(if_inst), .if_pc_i(if_pc), .id_vld_o(id_vld_b), .ex_rdy_i(ex_rdy),
    .id_pc_o(pc_b), .id_grp_o(grp_b), .id_info_o(info_b), .id_sys_o(sys_b), .id_ill_o(ill_b),
    .id_rs1_vld_o(rs1v_b), .id_rs2_vld_o(rs2v_b), .id_rd_vld_o(rdv_b),
    .id_rs1_idx_o(rs1i_b), .id_rs2_idx_o(rs2i_b), .id_rd_idx_o(rdi_b), .id_imm_o(imm_b),
    .id_load_size_o(lsz_b), .id_store_size_o(ssz_b), .id_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t mq[$];
  int    n_cmp, n_bad;

  // ISA-level reference: classify the word, then fill in the fields that class defines.
  function automatic dec_t ref_decode(input logic [31:0] w, input bit en_m, input bit en_csr);
    dec_t        r;
    bit          legal;
    bit          csr;
    logic [2:0]  f3;
    logic [6:0]  f7;
    r = '0; legal = 1'b1; csr = 1'b0;
    f3 = w[14:12]; f7 = w[31:25];
    case (w[6:0])
      7'h33: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && en_m);
        r.grp = (f7 == 7'h01) ? 5'b00010 : 5'b00001;
        r.info = {3'b000, f7 == 7'h20, f3};
        r.rs1_vld = 1; r.rs2_vld = 1; r.rd_vld = 1;
      end
      7'h13: begin
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
        r.grp = 5'b00001;
        r.info = {3'b001, f3 == 3'd5 && f7 == 7'h20, f3};
        r.rs1_vld = 1; r.rd_vld = 1;
        r.imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, w[24:20]} : 32'($signed(w[31:20]));
      end
      7'h37: begin r.grp = 5'b00001; r.info = 7'b0100000; r.rd_vld = 1; r.imm = w & 32'hFFFF_F000; end
      7'h17: begin r.grp = 5'b00001; r.info = 7'b1000000; r.rd_vld = 1; r.imm = w & 32'hFFFF_F000; end
      7'h63: begin
        legal = (f3 != 3'd2 && f3 != 3'd3);
        r.grp = 5'b01000; r.info = {4'b0000, f3}; r.rs1_vld = 1; r.rs2_vld = 1;
        r.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      end
      7'h6F: begin
        r.grp = 5'b01000; r.info = 7'b0100000; r.rd_vld = 1;
        r.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      end
      7'h67: begin
        legal = (f3 == 3'd0);
        r.grp = 5'b01000; r.info = 7'b1000000; r.rs1_vld = 1; r.rd_vld = 1;
        r.imm = 32'($signed(w[31:20]));
      end
      7'h03: begin
        legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        r.grp = 5'b00100; r.info = {4'b1000, f3}; r.rs1_vld = 1; r.rd_vld = 1;
        r.imm = 32'($signed(w[31:20])); r.load_size = f3[1:0];
      end
      7'h23: begin
        legal = (f3 <= 3'd2);
        r.grp = 5'b00100; r.info = {4'b0100, f3}; r.rs1_vld = 1; r.rs2_vld = 1;
        r.imm = 32'($signed({w[31:25], w[11:7]})); r.store_size = f3[1:0];
      end
      7'h0F: begin
        if (f3 == 3'd0)      r.sys = 6'b000001;
        else if (f3 == 3'd1) r.sys = 6'b000010;
        else                 legal = 1'b0;
      end
      7'h73: begin
        if (f3 == 3'd0) begin
          if (w == 32'h0000_0073)      r.sys = 6'b000100;
          else if (w == 32'h0010_0073) r.sys = 6'b001000;
          else if (w == 32'h3020_0073) r.sys = 6'b010000;
          else if (w == 32'h1050_0073) r.sys = 6'b100000;
          else legal = 1'b0;
        end else if (f3 == 3'd4 || !en_csr) begin
          legal = 1'b0;
        end else begin
          csr = 1'b1;
          r.grp = 5'b10000; r.info = {2'b00, f3[2], 1'b0, f3};
          r.rs1_vld = !f3[2]; r.rd_vld = 1; r.imm = {20'b0, w[31:20]};
        end
      end
      default: legal = 1'b0;
    endcase
    if (r.rs1_vld || csr) r.rs1_idx = w[19:15];
    if (r.rs2_vld)        r.rs2_idx = w[24:20];
    if (r.rd_vld)         r.rd_idx  = w[11:7];
    if (w[1:0] != 2'b11 || w == 32'h0 || w == 32'hFFFF_FFFF) legal = 1'b0;
    if (!legal) begin r = '0; r.ill = 1'b1; end
    return r;
  endfunction

  function automatic logic [6:0] rand_f7();
    case ($urandom_range(0, 3))
      0: return 7'h00;
      1: return 7'h20;
      2: return 7'h01;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [31:0] sysw[4];
    sysw[0] = 32'h0000_0073; sysw[1] = 32'h0010_0073; sysw[2] = 32'h3020_0073; sysw[3] = 32'h1050_0073;
    w = $urandom;
    case ($urandom_range(0, 15))
      0:  begin w[6:0] = 7'h33; w[31:25] = rand_f7(); end
      1:  begin w[6:0] = 7'h13; w[31:25] = rand_f7(); end
      2:  w[6:0] = 7'h37;
      3:  w[6:0] = 7'h17;
      4:  w[6:0] = 7'h63;
      5:  w[6:0] = 7'h6F;
      6:  begin w[6:0] = 7'h67; if ($urandom_range(0, 1) == 0) w[14:12] = 3'd0; end
      7:  w[6:0] = 7'h03;
      8:  w[6:0] = 7'h23;
      9:  begin w[6:0] = 7'h0F; w[14:12] = 3'($urandom_range(0, 1)); end
      10: begin w[6:0] = 7'h73; w[14:12] = 3'($urandom_range(5, 7)) - 3'(4 * $urandom_range(0, 1)); end
      11: w = sysw[$urandom_range(0, 3)];
      12: begin w[6:0] = 7'h73; w[14:12] = 3'd0; end
      13: ;
      14: w = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
      default: begin w[6:0] = 7'h33; w[1:0] = 2'($urandom_range(0, 2)); end
    endcase
    if (w[6:0] == 7'h0F && w[14:13] != 2'b00) w[14:13] = 2'b00;
    if (w[6:0] == 7'h73 && w[14:12] == 3'd4) w[14:12] = 3'd1;
    return w;
  endfunction

  task automatic drive(input logic vld, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    if_vld = vld; if_inst = inst; if_pc = pc; ex_rdy = rdy; flush = fl;
  endtask

  // Apply the spec's handshake rules to the model for the inputs now driven, then advance a cycle.
  task automatic tick();
    bit acc, deq;
    acc = if_vld && (mq.size() < DEPTH) && !flush;
    deq = (mq.size() > 0) && ex_rdy && !flush;
    if (flush) mq.delete();
    else begin
      if (deq) mq.delete(0);
      if (acc) mq.push_back('{pc: if_pc, inst: if_inst});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++; if (id_vld_a !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", id_vld_a); end
    n_cmp++; if (if_rdy_a !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b want 1", if_rdy_a); end
    n_cmp++; if (cnt_a !== 2'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
    n_cmp++; if (act_a !== '0 || act_b !== '0) begin n_bad++; $display("FAIL reset_payload: got %h / %h want 0", act_a, act_b); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    n_cmp++; if (id_vld_a !== 1'b0 || if_rdy_a !== 1'b1) begin n_bad++; $display("FAIL post_reset: vld %b rdy %b want 0 1", id_vld_a, if_rdy_a); end
  endtask

  task automatic test_basic();
    drive(1, 32'h0051_0093, 32'h0000_1000, 1, 0); tick();
    n_cmp++; if (id_vld_a !== 1'b1) begin n_bad++; $display("FAIL addi_vld: got %b want 1", id_vld_a); end
    n_cmp++; if (grp_a !== 5'b00001) begin n_bad++; $display("FAIL addi_grp: got %b want 00001", grp_a); end
    n_cmp++; if (rs1i_a !== 5'd2 || rdi_a !== 5'd1) begin n_bad++; $display("FAIL addi_idx: rs1 %0d rd %0d want 2 1", rs1i_a, rdi_a); end
    n_cmp++; if (imm_a !== 32'd5) begin n_bad++; $display("FAIL addi_imm: got %h want 5", imm_a); end
    n_cmp++; if (ill_a !== 1'b0) begin n_bad++; $display("FAIL addi_ill: got %b want 0", ill_a); end
    n_cmp++; if (pc_a !== 32'h1000) begin n_bad++; $display("FAIL addi_pc: got %h want 1000", pc_a); end
    drive(0, 0, 0, 1, 0); tick();
    n_cmp++; if (id_vld_a !== 1'b0) begin n_bad++; $display("FAIL addi_drain: got %b want 0", id_vld_a); end
  endtask

  task automatic test_m_ext();
    drive(1, 32'h0220_81B3, 32'h0000_2000, 1, 0); tick();
    n_cmp++; if (ill_b !== 1'b1 || grp_b !== 5'b0 || rdv_b !== 1'b0) begin n_bad++; $display("FAIL mul_no_m: ill %b grp %b rdv %b want 1 00000 0", ill_b, grp_b, rdv_b); end
    n_cmp++; if (grp_a !== 5'b00010 || rdi_a !== 5'd3 || ill_a !== 1'b0) begin n_bad++; $display("FAIL mul_m: grp %b rd %0d ill %b want 00010 3 0", grp_a, rdi_a, ill_a); end
    drive(0, 0, 0, 1, 0); tick();
  endtask

  task automatic test_system();
    drive(1, 32'h0000_0073, 32'h3000, 1, 0); tick();
    n_cmp++; if (sys_a !== 6'b000100 || grp_a !== 5'b0 || rdv_a !== 1'b0) begin n_bad++; $display("FAIL ecall: sys %b grp %b rdv %b want 000100 0 0", sys_a, grp_a, rdv_a); end
    drive(1, 32'h0000_0000, 32'h3004, 1, 0); tick();
    n_cmp++; if (ill_a !== 1'b1 || pc_a !== 32'h3004) begin n_bad++; $display("FAIL zero_word: ill %b pc %h want 1 3004", ill_a, pc_a); end
    drive(1, 32'h0083_2283, 32'h3008, 1, 0); tick();
    n_cmp++; if (grp_a !== 5'b00100 || info_a[6] !== 1'b1 || lsz_a !== 2'b10 || imm_a !== 32'd8) begin n_bad++; $display("FAIL lw: grp %b info %b size %b imm %h want 00100 load 10 8", grp_a, info_a, lsz_a, imm_a); end
    n_cmp++; if (rdi_a !== 5'd5 || rs1i_a !== 5'd6) begin n_bad++; $display("FAIL lw_idx: rd %0d rs1 %0d want 5 6", rdi_a, rs1i_a); end
    drive(0, 0, 0, 1, 0); tick();
  endtask

  task automatic test_full();
    drive(1, 32'h0051_0093, 32'h100, 0, 0); tick();
    n_cmp++; if (if_rdy_a !== 1'b1 || cnt_a !== 2'd1) begin n_bad++; $display("FAIL full_1: rdy %b cnt %0d want 1 1", if_rdy_a, cnt_a); end
    drive(1, 32'h0022_0233, 32'h104, 0, 0); tick();
    n_cmp++; if (if_rdy_a !== 1'b0 || cnt_a !== 2'd2) begin n_bad++; $display("FAIL full_2: rdy %b cnt %0d want 0 2", if_rdy_a, cnt_a); end
    drive(1, 32'h0083_2283, 32'h108, 0, 0); tick();
    n_cmp++; if (cnt_a !== 2'd2 || pc_a !== 32'h100) begin n_bad++; $display("FAIL full_hold: cnt %0d pc %h want 2 100", cnt_a, pc_a); end
    drive(1, 32'h0083_2283, 32'h108, 1, 0);
    n_cmp++; if (if_rdy_a !== 1'b0) begin n_bad++; $display("FAIL full_no_comb: rdy %b want 0", if_rdy_a); end
    tick();
    n_cmp++; if (cnt_a !== 2'd1 || pc_a !== 32'h104 || if_rdy_a !== 1'b1) begin n_bad++; $display("FAIL full_deq1: cnt %0d pc %h rdy %b want 1 104 1", cnt_a, pc_a, if_rdy_a); end
    tick();
    n_cmp++; if (cnt_a !== 2'd1 || pc_a !== 32'h108) begin n_bad++; $display("FAIL full_third: cnt %0d pc %h want 1 108", cnt_a, pc_a); end
    drive(0, 0, 0, 1, 0); tick();
    n_cmp++; if (cnt_a !== 2'd0) begin n_bad++; $display("FAIL full_drain: cnt %0d want 0", cnt_a); end
  endtask

  task automatic test_flush();
    drive(1, 32'h0051_0093, 32'h200, 0, 0); tick();
    drive(1, 32'h0051_0093, 32'h204, 0, 0); tick();
    drive(1, 32'h0051_0093, 32'h208, 1, 1); tick();
    n_cmp++; if (cnt_a !== 2'd0 || id_vld_a !== 1'b0 || if_rdy_a !== 1'b1) begin n_bad++; $display("FAIL flush_full: cnt %0d vld %b rdy %b want 0 0 1", cnt_a, id_vld_a, if_rdy_a); end
    drive(1, 32'h0051_0093, 32'h20C, 0, 0); tick();
    drive(1, 32'h0051_0093, 32'h210, 1, 1); tick();
    n_cmp++; if (cnt_a !== 2'd0 || act_a !== '0) begin n_bad++; $display("FAIL flush_enq: cnt %0d rec %h want 0 0", cnt_a, act_a); end
    drive(1, 32'h0051_0093, 32'h214, 0, 0); tick();
    n_cmp++; if (cnt_a !== 2'd1 || pc_a !== 32'h214) begin n_bad++; $display("FAIL flush_after: cnt %0d pc %h want 1 214", cnt_a, pc_a); end
    drive(0, 0, 0, 1, 0); tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h0051_0093, 32'h400, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    mq.delete();
    n_cmp++; if (id_vld_a !== 1'b0 || if_rdy_a !== 1'b1 || cnt_a !== 2'd0) begin n_bad++; $display("FAIL rst_mid_ctl: vld %b rdy %b cnt %0d want 0 1 0", id_vld_a, if_rdy_a, cnt_a); end
    n_cmp++; if (act_a !== '0) begin n_bad++; $display("FAIL rst_mid_payload: got %h want 0", act_a); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    drive(1, 32'h0083_2283, 32'h500, 0, 0); tick();
    n_cmp++; if (cnt_a !== 2'd1 || pc_a !== 32'h500 || grp_a !== 5'b00100) begin n_bad++; $display("FAIL rst_mid_push: cnt %0d pc %h grp %b want 1 500 00100", cnt_a, pc_a, grp_a); end
    drive(0, 0, 0, 1, 0); tick();
  endtask

  task automatic test_random();
    dec_rec_t exp_a, exp_b;
    int       sz;
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 4) < 3, $urandom_range(0, 31) == 0);
      sz = mq.size();
      exp_a = '0; exp_b = '0;
      if (sz > 0) begin
        exp_a = '{pc: mq[0].pc, dec: ref_decode(mq[0].inst, 1'b1, 1'b1)};
        exp_b = '{pc: mq[0].pc, dec: ref_decode(mq[0].inst, 1'b0, 1'b0)};
      end
      n_cmp++; if (id_vld_a !== (sz != 0) || id_vld_b !== (sz != 0)) begin n_bad++; $display("FAIL rnd_vld @%0d: got %b/%b want %b", i, id_vld_a, id_vld_b, sz != 0); end
      n_cmp++; if (if_rdy_a !== (sz != DEPTH) || if_rdy_b !== (sz != DEPTH)) begin n_bad++; $display("FAIL rnd_rdy @%0d: got %b/%b want %b", i, if_rdy_a, if_rdy_b, sz != DEPTH); end
      n_cmp++; if (cnt_a !== 2'(sz) || cnt_b !== 2'(sz)) begin n_bad++; $display("FAIL rnd_cnt @%0d: got %0d/%0d want %0d", i, cnt_a, cnt_b, sz); end
      n_cmp++; if (act_a !== exp_a) begin n_bad++; $display("FAIL rnd_rec_a @%0d inst %h: got %h want %h", i, (sz > 0) ? mq[0].inst : 32'h0, act_a, exp_a); end
      n_cmp++; if (act_b !== exp_b) begin n_bad++; $display("FAIL rnd_rec_b @%0d inst %h: got %h want %h", i, (sz > 0) ? mq[0].inst : 32'h0, act_b, exp_b); end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_m_ext();
    test_system();
    test_full();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/k423_id_decq.md
# k423_id_decq

Decoded-instruction queue for the ID stage. It accepts raw RV32 instructions from IF over a valid/ready handshake and decodes them combinationally at enqueue. Each decoded record is stored in a parametrised-depth FIFO, and the head entry is presented to EX/issue over a second valid/ready handshake. It extends plain decode with M/Zicsr enable options, system-instruction decode (fence, fence.i, ecall, ebreak, mret, wfi), illegal-instruction flagging, flush, and buffering that decouples IF from EX back-pressure.

## Interface
- `DEPTH`, default 2: queue entries; power of two, ≥2.
- `EN_M`, default 1: 1 = decode RV32M into MDU group; 0 = M-extension encodings are illegal.
- `EN_ZICSR`, default 1: 1 = decode CSR ops into CSR group; 0 = CSR encodings are illegal.
- `clk_i`, in, 1: clock; single clock domain.
- `rst_n_i`, in, 1: reset, asynchronous assert, active-low.
- `flush_i`, in, 1: discard all queued entries and any same-cycle enqueue.
- `if_vld_i`, in, 1: IF instruction valid.
- `if_rdy_o`, out, 1: queue can accept.
- `if_inst_i`, in, `CORE_INST_W`: raw instruction.
- `if_pc_i`, in, `CORE_XLEN`: instruction PC.
- `id_vld_o`, out, 1: head entry valid.
- `ex_rdy_i`, in, 1: consumer accepts head.
- `id_pc_o`, out, `CORE_XLEN`: head PC.
- `id_grp_o`, out, `INST_GRP_W`: one-hot group (ALU/MDU/LSU/BJU/CSR); all zero for system/illegal.
- `id_info_o`, out, `INST_INFO_W`: group info vector, same encoding as the existing decode bus.
- `id_sys_o`, out, `INST_SYS_W` (6): one-hot {wfi, mret, ebreak, ecall, fence_i, fence}.
- `id_ill_o`, out, 1: head entry is an illegal instruction.
- `id_rs1_vld_o`/`id_rs2_vld_o`/`id_rd_vld_o`, out, 1 each: operand valids.
- `id_rs1_idx_o`/`id_rs2_idx_o`/`id_rd_idx_o`, out, `INST_RSDIDX_W`: operand indices.
- `id_imm_o`, out, `CORE_XLEN`: selected immediate.
- `id_load_size_o`/`id_store_size_o`, out, `RSD_SIZE_W`: access sizes.
- `id_cnt_o`, out, `$clog2(DEPTH+1)`: occupancy.

## Operation
- **Enqueue** when `if_vld_i & if_rdy_o & ~flush_i`. The decoded record {pc, grp, info, sys, ill, operands, imm, sizes} is written at `wptr`.
- **Dequeue** when `id_vld_o & ex_rdy_i & ~flush_i`. `rptr` advances.
- **Handshake signals:**
  - `if_rdy_o = (cnt != DEPTH)`, registered-state only, with no combinational path from `ex_rdy_i`. When full, a same-cycle dequeue does not open a slot until the next cycle.
  - `id_vld_o = (cnt != 0)`.
- **Head payload:** all payload outputs come from the head entry and are forced to zero when `id_vld_o = 0`.
- **Illegal** is set when any of the following holds:
  - `inst[1:0] != 2'b11`;
  - opcode is not LOAD/STORE/OP/OP-IMM/LUI/AUIPC/BRANCH/JAL/JALR/MISC-MEM/SYSTEM;
  - OP with funct7 other than 0000000, 0100000 (only for funct3 000/101), or 0000001 (only when `EN_M`);
  - SLLI/SRLI/SRAI with an invalid funct7;
  - BRANCH funct3 is 010 or 011;
  - load funct3 is 011, 110 or 111;
  - store funct3 > 010;
  - JALR funct3 != 000;
  - CSR op when `!EN_ZICSR`;
  - SYSTEM funct3 = 000 that is not one of the four listed encodings;
  - all-zero or all-one word.
- **Illegal entries:** grp = 0, sys = 0, all reg valids = 0, imm = 0.
- **Fence/fence.i/ecall/ebreak/mret/wfi:** grp = 0, no rd write; the matching `id_sys_o` bit is set.
- **Pointers:** `log2(DEPTH)` bits, natural wrap.
- **Occupancy:** `cnt` is incremented on enqueue only, decremented on dequeue only, and unchanged when both occur.
- **Flush:** highest priority. On the next edge `cnt`, `wptr` and `rptr` are 0. The same-cycle enqueue and dequeue are both void.

## Timing
- **Reset values:** `cnt`, `wptr` and `rptr` are 0. Consequently `id_vld_o = 0`, `if_rdy_o = 1`, all payload outputs 0, and `id_cnt_o = 0`.
- **Reset mid-operation:** asynchronous; all entries are dropped immediately.
- **Latency:** an instruction accepted at edge N is visible at `id_vld_o` in the cycle after edge N. There is no combinational IF-to-EX path.
- **Throughput:** 1 instruction/cycle sustained when `ex_rdy_i = 1`, with DEPTH ≥ 2.
- **Full:** `if_rdy_o` drops in the cycle after the enqueue that fills the queue.
- **Empty:** `ex_rdy_i` is ignored.
- **Storage:** entry storage has no reset (payload is gated by `id_vld_o`). Pointer and count flops use asynchronous reset.

## Structure
- **Package `k423_id_pkg`:**
  - `INST_SYS_W` and the sys bit positions;
  - packed struct `dec_rec_t` for the stored record;
  - RV32 opcode constants (LOAD…SYSTEM).
- **Sub-module `k423_id_decode_rv32`:** purely combinational `inst` → `dec_rec_t` (minus pc), parametrised by `EN_M`/`EN_ZICSR`.
- **Top level:** FIFO storage, pointers, count, handshake and flush.

## Test plan
- **Reset and basic pass-through:** reset, then push `addi x1,x2,5` (0x00510093) with `ex_rdy_i=1`.
  - Next cycle: `id_vld_o=1`, ALU group, `rs1_idx=2`, `rd_idx=1`, `imm=5`, `id_ill_o=0`.
- **M disabled:** `EN_M=0`, push `mul x3,x1,x2` (0x022081B3).
  - `id_ill_o=1`, `id_grp_o=0`, `rd_vld=0`.
  - With `EN_M=1`: MDU group, `rd_idx=3`.
- **System and illegal encodings:**
  - push `ecall` (0x00000073) → `id_sys_o[ecall]=1`, `grp=0`;
  - push 0x00000000 → `id_ill_o=1`;
  - push `lw x5,8(x6)` (0x00832283) → LSU load, word size, `imm=8`.
- **Full / back-pressure:** DEPTH=2, `ex_rdy_i=0`, push 3 instructions.
  - `if_rdy_o` goes low after the 2nd; `id_cnt_o=2`.
  - Raise `ex_rdy_i`: the 3rd is accepted one cycle after the first dequeue, and order is preserved.
- **Flush:** queue holds 2 entries; assert `flush_i` together with `if_vld_i`.
  - Next cycle: `id_cnt_o=0`, `id_vld_o=0`, the pushed instruction is not stored, `if_rdy_o=1`.
- **Mid-stream reset:** drop `rst_n_i` while the queue is half full.
  - Outputs go to reset values immediately.
  - After release, the first push appears unaffected by stale entries.
